data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
Memory-side responder for the CPU's MEM-stage load/store port. It replaces the single-cycle data memory with a handshaked, fixed-latency RAM and adds one memory-mapped LED register. It sits between the EX/MEM pipeline buffer (the initiator) and on-chip storage. It services one access at a time with byte/half/word/dword sizes, little-endian lanes, and error reporting.

Parameters:
Nbits, 64, data and address width
DEPTH_WORDS, 256, number of 64-bit RAM words; byte address space is 0 to DEPTH_WORDS*8-1
LATENCY, 2, cycles spent in WAIT; must be at least 1
LED_ADDR, 64'h0000_0000_0000_1000, byte address of the LED register; must lie outside the RAM range

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
req_valid  input  1  initiator presents a request
req_ready  output  1  responder accepts a request this cycle
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 dword
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  Nbits  byte address
req_wdata  input  Nbits  store data, right-aligned
rsp_valid  output  1  response available
rsp_ready  input  1  initiator consumes the response
rsp_rdata  output  Nbits  load data, extended; 0 for stores and errors
rsp_err  output  1  misaligned or unmapped access
led  output  1  LED register bit 0

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on port rst.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, led=0. RAM contents are not reset.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, capture write, size, unsigned, addr and wdata; load the counter with LATENCY-1; go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter is 0, perform the access and go to RESP. This is the commit edge.
  - Stores write RAM byte lanes on this edge only.
  - Load data is registered into rsp_rdata on this edge.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On rsp_valid&rsp_ready, go to IDLE and clear rsp_valid.
  - rsp_rdata and rsp_err keep their values until the next commit.
- Throughput: latency from acceptance to rsp_valid is LATENCY+1 cycles. With rsp_ready tied high, one access completes every LATENCY+2 cycles. No request overlap.
- Alignment: the address must be a multiple of 2^size.
  - Otherwise rsp_err=1, rsp_rdata=0, and no write occurs.
- Mapping:
  - Addresses below DEPTH_WORDS*8 select RAM word addr[..:3], lane offset addr[2:0].
  - addr==LED_ADDR selects the LED register.
  - Any other address sets rsp_err=1, rsp_rdata=0, and no side effect.
- LED register: dword access only; any other size gives rsp_err=1.
  - A store sets led=wdata[0].
  - A load returns {63'b0, led}.
- Stores: write size-bytes of req_wdata[8*2^size-1:0] into lanes starting at addr[2:0]. Other lanes are untouched.
- Loads:
  - Extract size-bytes from the addressed lanes.
  - Sign-extend from the top extracted bit unless req_unsigned.
  - For a dword, req_unsigned is ignored.
- Input rules: inputs outside IDLE are ignored. req_valid while busy is held off by req_ready=0 and is not dropped by the initiator.
- Reset mid-operation: a reset asserted in WAIT before the commit edge leaves RAM and led unchanged. A response pending in RESP is discarded.

Decomposition:
- Package mem_resp_pkg contains:
  - state_t enum {IDLE, WAIT, RESP}
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D
  - default LED_ADDR constant
  - function for the alignment check
- Sub-module load_store_align (combinational), with two functions:
  - generate the byte-enable mask and shifted write data from size and offset
  - extract and extend load data
- RAM is a behavioural array inside data_mem_responder with a per-byte write enable.

Test Plan:
- Dword store then load: store addr 0x10, data 0x1122334455667788; load 0x10 -> rdata 0x1122334455667788, err 0. rsp_valid rises exactly LATENCY+1 cycles after acceptance.
- Byte lanes: store byte 0xF0 at 0x13, then signed byte load 0x13 -> 0xFFFFFFFFFFFFFFF0. Unsigned byte load -> 0xF0. Dword load 0x10 -> 0x11223344F0667788.
- Half/word extension: store word 0x80000001 at 0x20. Signed word load -> 0xFFFFFFFF80000001. Unsigned -> 0x0000000080000001. Signed half load 0x22 -> 0xFFFFFFFFFFFF8000.
- Errors:
  - half load at 0x21 -> err 1, rdata 0
  - store at 0x4000 (unmapped) -> err 1, no RAM change
  - word store to LED_ADDR -> err 1, led unchanged
- LED plus backpressure: dword store 1 to LED_ADDR -> led=1 after the commit edge. Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_err stay stable and req_ready stays 0. Load LED_ADDR -> rdata 1.
- Reset mid-op: accept a store of 0xAA at 0x30; drive rst low in WAIT before commit; release -> outputs at reset values; load 0x30 returns the prior contents.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the MEM-stage data responder.
// Size encodings follow the load/store funct3 low bits: 00 byte .. 11 dword.
package mem_resp_pkg;

    localparam int DW = 64;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [DW-1:0] LED_ADDR_DEF = 64'h0000_0000_0000_1000;

    typedef struct packed {
        logic [7:0]    be;
        logic [DW-1:0] data;
    } wr_lanes_t;

    // Natural alignment: the byte offset must be a multiple of the access size.
    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~off[0];
            SZ_W:    ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Little-endian lane steering: byte enables and shifted store data going in,
// extraction and sign/zero extension of load data coming out.
module load_store_align
    import mem_resp_pkg::*;
(
    input  logic [1:0]    i_size,
    input  logic [2:0]    i_off,
    input  logic          i_unsigned,
    input  logic [DW-1:0] i_wdata,
    input  logic [DW-1:0] i_rword,
    output logic [7:0]    o_be,
    output logic [DW-1:0] o_wdata,
    output logic [DW-1:0] o_rdata
);

    function automatic wr_lanes_t store_lanes(input logic [1:0] size, input logic [2:0] off,
                                              input logic [DW-1:0] wdata);
        wr_lanes_t  r;
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        r.be   = m << off;
        r.data = wdata << {off, 3'b000};
        return r;
    endfunction

    function automatic logic [DW-1:0] load_extend(input logic [1:0] size, input logic [2:0] off,
                                                   input logic uns, input logic [DW-1:0] word);
        logic [DW-1:0] s;
        logic [DW-1:0] r;
        s = word >> {off, 3'b000};
        case (size)
            SZ_B:    r = uns ? {56'b0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
            SZ_H:    r = uns ? {48'b0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            SZ_W:    r = uns ? {32'b0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    wr_lanes_t w_lanes;

    always_comb begin
        w_lanes = store_lanes(i_size, i_off, i_wdata);
        o_be    = w_lanes.be;
        o_wdata = w_lanes.data;
        o_rdata = load_extend(i_size, i_off, i_unsigned, i_rword);
    end

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked fixed-latency data RAM plus one memory-mapped LED bit, serving
// the MEM-stage port one access at a time (IDLE -> WAIT -> RESP).
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int              Nbits       = 64,
    parameter int              DEPTH_WORDS = 256,
    parameter int              LATENCY     = 2,
    parameter logic [Nbits-1:0] LED_ADDR   = LED_ADDR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [Nbits-1:0] req_addr,
    input  logic [Nbits-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [Nbits-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             led
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [Nbits-1:0] RAM_BYTES = Nbits'(DEPTH_WORDS * 8);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_write;
    logic [1:0]       r_size;
    logic             r_uns;
    logic [Nbits-1:0] r_addr;
    logic [Nbits-1:0] r_wdata;
    logic [Nbits-1:0] r_rdata;
    logic             r_err;
    logic             r_led;

    logic [Nbits-1:0] r_mem [DEPTH_WORDS];

    logic [AW-1:0]    w_widx;
    logic             w_in_ram;
    logic             w_is_led;
    logic             w_err;
    logic             w_commit;
    logic             w_ram_we;
    logic [7:0]       w_be;
    logic [Nbits-1:0] w_wdata_sh;
    logic [Nbits-1:0] w_rword;
    logic [Nbits-1:0] w_rdata_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = WAIT;
            end
            WAIT: begin
                if (r_cnt == '0) w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Decode works on the captured request so the initiator may change its
    // inputs freely once the access is accepted.
    assign w_widx   = r_addr[AW+2:3];
    assign w_in_ram = (r_addr < RAM_BYTES);
    assign w_is_led = (r_addr == LED_ADDR);
    assign w_err    = ~is_aligned(r_size, r_addr[2:0]) |
                      (w_is_led ? (r_size != SZ_D) : ~w_in_ram);
    assign w_commit = (r_state == WAIT) && (r_cnt == '0);
    assign w_ram_we = w_commit & r_write & w_in_ram & ~w_err;
    assign w_rword  = r_mem[w_widx];

    load_store_align u_align (
        .i_size     (r_size),
        .i_off      (r_addr[2:0]),
        .i_unsigned (r_uns),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int b = 0; b < 8; b++) begin
                if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_size  <= SZ_B;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_write <= req_write;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= CW'(LATENCY - 1);
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end

            // Response fields only change here, so they stay stable under backpressure.
            if (w_commit) begin
                r_err <= w_err;
                if (w_err || r_write) r_rdata <= '0;
                else if (w_is_led)    r_rdata <= {{(Nbits-1){1'b0}}, r_led};
                else                  r_rdata <= w_rdata_ext;
                if (r_write && w_is_led && !w_err) r_led <= r_wdata[0];
            end
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign led       = r_led;

endmodule
